hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
// - EX-stage multi-cycle multiply/divide unit with the HI/LO register pair. Sits beside the ALU.
// - Operands come from the ALU operand-1 and operand-2 selectors (rs, rt).
// - hi/lo feed the EX result path for MFHI/MFLO; that result flows on to the write-back data selector.
// - Asks the hazard unit for a pipeline stall while an operation is in flight.
// PARAMETERS
// - WIDTH   32  operand and HI/LO width
// - CNT_W   6   iteration counter width; must hold the value WIDTH
// PORTS
// - clk        in   1      pipeline clock; all state changes on the rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - start      in   1      EX holds a valid MULT/MULTU/DIV/DIVU/MTHI/MTLO
// - op         in   3      0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 = NONE
// - opnd_a     in   WIDTH  rs value: multiplicand / dividend / MTHI-MTLO source
// - opnd_b     in   WIDTH  rt value: multiplier / divisor
// - rd_hilo    in   1      EX holds MFHI/MFLO
// - flush      in   1      EX kill (branch/exception); aborts any operation
// - hi         out  WIDTH  HI register
// - lo         out  WIDTH  LO register
// - busy       out  1      operation in flight
// - stall_req  out  1      combinational stall request to the hazard unit
// - done       out  1      one-cycle pulse: HI/LO were just written by MUL/DIV
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
//   - Reset mid-operation discards the operation with no partial HI/LO write.
// - States:
//   - IDLE -> MUL | DIV when start=1 with op MULT/MULTU or DIV/DIVU (edge E0).
//   - MUL | DIV -> FIN after WIDTH iteration edges (E1..E32).
//   - FIN -> IDLE at E33; this edge writes HI/LO.
// - At E0:
//   - latch |opnd_a| and |opnd_b| (signed ops) or the raw values (unsigned ops);
//   - latch the result signs;
//   - counter=0; busy=1.
// - MUL: shift-add, one multiplier bit per edge; 2*WIDTH-bit accumulator. At FIN: hi = product[63:32], lo = product[31:0].
//   - Signed result negated when sign(a) != sign(b).
// - DIV: restoring, one quotient bit per edge. At FIN: lo = quotient, hi = remainder.
//   - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
// - Divide by zero: lo = 32'hFFFF_FFFF, hi = opnd_a. Same for DIV and DIVU; no trap.
// - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
// - Timing of the E33 edge: busy falls to 0, and done is 1 for exactly the following cycle.
//   - MUL/DIV latency: start at E0, HI/LO visible after E33.
// - MTHI/MTLO (start=1 in IDLE): hi or lo <= opnd_a at E0. No busy, no done, no stall.
// - stall_req = busy & (start | rd_hilo).
// - A start while busy is ignored; the stalled instruction reissues once busy=0.
// - MFHI/MFLO in IDLE reads hi/lo directly with no stall.
// - flush=1: at the next edge, state=IDLE and busy=0. HI/LO are unchanged and done stays 0.
//   - flush together with start: flush wins, nothing is latched, MTHI/MTLO are suppressed.
//   - flush in FIN: the write is suppressed.
// - start with op NONE or 7: no effect.
// - Width rules: the accumulator/remainder register is 2*WIDTH bits.
//   - Negation is two's complement in WIDTH bits; 32'h8000_0000 magnitude is treated as unsigned 2^31.
// CONFIGURATION
// - MULDIV_FAST_MUL_EN defined:
//   - MULT/MULTU compute the full product in one combinational step and register it at E0.
//   - Then go straight to FIN; HI/LO are written at E1 and done=1 in the cycle after E1.
//   - busy=1 for one cycle only.
//   - DIV is unchanged.
// - MULDIV_FAST_MUL_EN undefined: the 33-cycle iterative multiplier described above.
// TESTING
// - MULTU 0xFFFF_FFFF x 0xFFFF_FFFF:
//   - hi=0xFFFF_FFFE, lo=0x0000_0001;
//   - done pulses exactly 34 cycles after start (2 with MULDIV_FAST_MUL_EN).
// - MULT -3 x 7: hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. DIV -7 / 2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
// - DIVU 100 / 0: lo=0xFFFF_FFFF, hi=100. DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
// - Start DIVU 10/3, then hold rd_hilo=1 from cycle 5:
//   - stall_req=1 until busy falls; afterwards hi=1, lo=3.
//   - A second start during busy leaves HI/LO unchanged.
// - MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles:
//   - hi=0x1234, lo=0x5678; busy and stall_req never assert.
// - Flush at cycle 10 of a DIV: HI/LO keep prior values, busy=0 next cycle, no done.
//   - Assert rst_n=0 mid-MUL: hi=lo=0 and busy=0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO register pair.
// Define MULDIV_FAST_MUL_EN for a single-step combinational multiplier.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req,
    output logic             done
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
    logic [W2-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, rneg_q, div_q, dz_q, done_q;

    logic             is_mul, is_div, is_sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_mul = (op == 3'd1) || (op == 3'd2);
        is_div = (op == 3'd3) || (op == 3'd4);
        is_sgn = (op == 3'd1) || (op == 3'd3);
        sa     = is_sgn & opnd_a[WIDTH-1];
        sb     = is_sgn & opnd_b[WIDTH-1];
        mag_a  = sa ? -opnd_a : opnd_a;
        mag_b  = sb ? -opnd_b : opnd_b;
    end

    logic [WIDTH:0]   sum;
    logic [W2-1:0]    mul_nx, div_nx;
    logic             ge;
    logic [WIDTH-1:0] diff;

    // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        sum    = {1'b0, acc_q[W2-1:WIDTH]}
               + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        mul_nx = {sum, acc_q[WIDTH-1:1]};
        ge     = acc_q[W2-1:WIDTH-1] >= {1'b0, b_q};
        diff   = acc_q[W2-2:WIDTH-1] - b_q;
        div_nx = ge ? {diff, acc_q[WIDTH-2:0], 1'b1}
                    : {acc_q[W2-2:0], 1'b0};
    end

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] rem, quo, fin_hi, fin_lo;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        rem  = acc_q[W2-1:WIDTH];
        quo  = acc_q[WIDTH-1:0];
        if (!div_q) begin
            fin_hi = prod[W2-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            fin_hi = rneg_q ? -a_q : a_q;
            fin_lo = {WIDTH{1'b1}};
        end else begin
            fin_hi = rneg_q ? -rem : rem;
            fin_lo = neg_q ? -quo : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && (is_mul || is_div)) begin
                            a_q    <= mag_a;
                            b_q    <= mag_b;
                            neg_q  <= sa ^ sb;
                            rneg_q <= sa;
                            div_q  <= is_div;
                            dz_q   <= (opnd_b == '0);
                            cnt_q  <= '0;
                            if (is_div) begin
                                acc_q   <= {{WIDTH{1'b0}}, mag_a};
                                state_q <= S_DIV;
                            end else begin
`ifdef MULDIV_FAST_MUL_EN
                                acc_q   <= W2'(mag_a) * W2'(mag_b);
                                state_q <= S_FIN;
`else
                                acc_q   <= {{WIDTH{1'b0}}, mag_b};
                                state_q <= S_MUL;
`endif
                            end
                        end else if (start && op == 3'd5) begin
                            hi_q <= opnd_a;
                        end else if (start && op == 3'd6) begin
                            lo_q <= opnd_a;
                        end
                    end
                    S_MUL: begin
                        acc_q <= mul_nx;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIN;
                    end
                    S_DIV: begin
                        acc_q <= div_nx;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIN;
                    end
                    S_FIN: begin
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign stall_req = busy & (start | rd_hilo);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: driver pushes expected HI/LO,
// monitor pops on done and also checks stall_req every cycle.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] opnd_a = '0;
    logic [31:0] opnd_b = '0;
    logic        rd_hilo = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_req, done;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .rd_hilo(rd_hilo),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy),
        .stall_req(stall_req), .done(done)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] mhi = '0, mlo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic from the instruction definitions
    function automatic logic [63:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb2, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (o)
            3'd1: begin p = 64'(sa * sb2); return p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb2;
                r = sa % sb2;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("stall_req", {63'd0, stall_req},
                    {63'd0, busy & (start | rd_hilo)});
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, "_hilo"}, {hi, lo}, {e.hi, e.lo});
                        chk({e.nm, "_lat"}, 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy === 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) chk({nm, "_timeout"}, 64'd1, 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic go(input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input string nm);
        exp_t e;
        logic [63:0] r;
        @(negedge clk);
        start = 1'b1; op = o; opnd_a = a; opnd_b = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        r = ref_model(o, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cyc = cyc + ((o <= 3'd2) ? MUL_LAT : DIV_LAT);
        e.nm = nm;
        sb.push_back(e);
        mhi = e.hi;
        mlo = e.lo;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          dc;

        #1;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        go(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        wait_idle("multu_max");
        chk("multu_max_fixed", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        go(3'd1, -32'sd3, 32'd7, "mult_neg");
        wait_idle("mult_neg");
        chk("mult_neg_fixed", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        go(3'd3, -32'sd7, 32'd2, "div_neg");
        wait_idle("div_neg");
        chk("div_neg_fixed", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        go(3'd4, 32'd100, 32'd0, "divu_zero");
        wait_idle("divu_zero");
        chk("divu_zero_fixed", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        go(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        wait_idle("div_ovf");
        chk("div_ovf_fixed", {hi, lo}, 64'h0000_0000_8000_0000);

        // Stall while busy, and a start during busy must be ignored
        go(3'd4, 32'd10, 32'd3, "divu_stall");
        repeat (3) @(negedge clk);
        rd_hilo = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd5; opnd_a = 32'hDEAD_BEEF;
        #1;
        chk("stall_on_start", {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle("divu_stall");
        rd_hilo = 1'b0;
        chk("divu_stall_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

        // MTHI/MTLO back to back
        @(negedge clk);
        start = 1'b1; op = 3'd5; opnd_a = 32'h1234;
        #1;
        chk("mthi_nobusy", {63'd0, busy | stall_req}, 64'd0);
        @(negedge clk);
        op = 3'd6; opnd_a = 32'h5678;
        #1;
        chk("mtlo_nobusy", {63'd0, busy | stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1;
        chk("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);
        chk("mt_nodone", {63'd0, busy | done}, 64'd0);
        mhi = 32'h1234;
        mlo = 32'h5678;

        // Op NONE / 7 have no effect
        @(negedge clk);
        start = 1'b1; op = 3'd7; opnd_a = 32'hAAAA_AAAA;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("op_none", {hi, lo, 31'd0, busy}, {mhi, mlo, 32'd0});

        // Flush at cycle 10 of a DIV
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 3'd3; opnd_a = 32'd99; opnd_b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {hi, lo}, {mhi, mlo});
        chk("flush_nodone", 64'(done_cnt), 64'(dc));

        // Flush together with start suppresses MTHI
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd5; opnd_a = 32'hFEED;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'd0;
        #1;
        chk("flush_start", {hi, lo, 31'd0, busy}, {mhi, mlo, 32'd0});

        // Randomised MUL/DIV traffic
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            go(ro, ra, rb, "rand");
            wait_idle("rand");
        end

        // Async reset in the middle of a MUL
        go(3'd1, 32'd12345, 32'd678, "mul_reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_hilo", {hi, lo}, 64'd0);
        chk("reset_mid_busy", {63'd0, busy}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("reset_mid_after", {hi, lo, 31'd0, busy}, 96'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
